seq_detect_ctrl: RTL and testbench

- Configurable Moore-style serial sequence-detector controller for the serial-pattern datapath.
- Accepts a pattern, length, overlap mode and match target over a valid/ready config handshake.
- Arms on start, then scans a qualified serial bit stream and emits a registered one-cycle match pulse per detection.
- Counts matches and halts with done when the target count is reached; generalises the fixed 1010 detectors into one programmable, sequenced block.

---
 rtl/seq_detect_ctrl_pkg.sv | 26 ++
 rtl/seq_match_core.sv | 64 ++++++
 rtl/seq_detect_ctrl.sv | 161 ++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the serial sequence-detector controller.
// Holds the default widths, the controller state encodings and the
// pattern-length to bit-mask helper used by the match core.
package seq_detect_ctrl_pkg;

   localparam int unsigned DefaultPatW = 8;
   localparam int unsigned DefaultCntW = 8;

   // Widest mask len_to_mask can build; PAT_W must not exceed this.
   localparam int unsigned MaxMaskW = 32;

   typedef logic [1:0] state_t;

   localparam state_t StIdle = 2'd0;
   localparam state_t StRun  = 2'd1;
   localparam state_t StDone = 2'd2;

   // Returns a mask with the low 'len' bits set.
   function automatic logic [MaxMaskW-1:0] len_to_mask(input int unsigned len);
      if (len >= MaxMaskW) begin
         return '1;
      end
      return (MaxMaskW'(1) << len) - MaxMaskW'(1);
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and masked pattern compare.
// Ports:
//   clk, reset    - clock and asynchronous active-low reset
//   clear_i       - zero history and fill (arming a new run)
//   shift_i       - a qualified bit is consumed this cycle
//   bit_in_i      - serial data bit
//   pattern_i     - pattern, bit [len-1] is the oldest bit
//   len_i         - pattern length (1..PAT_W)
//   overlap_i     - keep fill after a match when set
//   hit_o         - combinational: the bit consumed this cycle completes a match
module seq_match_core
   import seq_detect_ctrl_pkg::*;
#(
   parameter int unsigned PAT_W = DefaultPatW
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear_i,
   input  logic                   shift_i,
   input  logic                   bit_in_i,
   input  logic [PAT_W-1:0]       pattern_i,
   input  logic [$clog2(PAT_W):0] len_i,
   input  logic                   overlap_i,
   output logic                   hit_o
);

   localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

   logic [PAT_W-1:0] hist_q, hist_d, hist_nxt;
   logic [LEN_W-1:0] fill_q, fill_d, fill_nxt;
   logic [PAT_W-1:0] mask;

   assign mask     = PAT_W'(len_to_mask(32'(len_i)));
   assign hist_nxt = {hist_q[PAT_W-2:0], bit_in_i};
   // Fill saturates at len so the window keeps sliding once full.
   assign fill_nxt = (fill_q < len_i) ? fill_q + LEN_W'(1) : len_i;

   assign hit_o = shift_i && (fill_nxt == len_i) &&
                  (((hist_nxt ^ pattern_i) & mask) == '0);

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      if (clear_i) begin
         hist_d = '0;
         fill_d = '0;
      end else if (shift_i) begin
         hist_d = hist_nxt;
         // Non-overlapping mode needs len fresh bits after each match.
         fill_d = (hit_o && !overlap_i) ? '0 : fill_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial sequence-detector controller.
// Accepts a pattern/length/overlap/target config in IDLE, arms on start,
// scans qualified serial bits in RUN and emits a registered one-cycle
// match pulse per detection, stopping in DONE when the target is reached.
// Ports:
//   clk, reset          - clock and asynchronous active-low reset
//   cfg_valid/cfg_ready - config handshake (ready only in IDLE)
//   cfg_pattern/len/overlap/target - configuration fields
//   cfg_err             - one-cycle pulse when an illegal length is rejected
//   start, abort        - arm detection / return to IDLE
//   bit_valid, bit_in   - qualified serial input
//   d                   - registered match pulse
//   match_count         - matches since last start (saturating)
//   busy, done          - RUN / DONE state indicators
module seq_detect_ctrl
   import seq_detect_ctrl_pkg::*;
#(
   parameter int unsigned PAT_W = DefaultPatW,
   parameter int unsigned CNT_W = DefaultCntW
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [PAT_W-1:0]       cfg_pattern,
   input  logic [$clog2(PAT_W):0] cfg_len,
   input  logic                   cfg_overlap,
   input  logic [CNT_W-1:0]       cfg_target,
   output logic                   cfg_err,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   bit_valid,
   input  logic                   bit_in,
   output logic                   d,
   output logic [CNT_W-1:0]       match_count,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

   state_t           state_q, state_d;
   logic [PAT_W-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             overlap_q, overlap_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic             loaded_q, loaded_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             d_q, d_d;
   logic             err_q, err_d;
   logic             len_ok;
   logic             clear;
   logic             shift;
   logic             hit;

   assign len_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
   // Abort suppresses the shift so a coincident match is never counted.
   assign shift   = (state_q == StRun) && bit_valid && !abort;

   seq_match_core #(
      .PAT_W (PAT_W)
   ) u_core (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (clear),
      .shift_i   (shift),
      .bit_in_i  (bit_in),
      .pattern_i (pattern_q),
      .len_i     (len_q),
      .overlap_i (overlap_q),
      .hit_o     (hit)
   );

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      target_d  = target_q;
      loaded_d  = loaded_q;
      cnt_d     = cnt_q;
      d_d       = 1'b0;
      err_d     = 1'b0;
      clear     = 1'b0;

      if (abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               // A config request takes priority over a coincident start.
               if (cfg_valid) begin
                  if (len_ok) begin
                     pattern_d = cfg_pattern;
                     len_d     = cfg_len;
                     overlap_d = cfg_overlap;
                     target_d  = cfg_target;
                     loaded_d  = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (start && loaded_q) begin
                  state_d = StRun;
                  cnt_d   = '0;
                  clear   = 1'b1;
               end
            end
            StRun: begin
               if (hit) begin
                  d_d   = 1'b1;
                  cnt_d = cnt_inc;
                  if ((target_q != '0) && (cnt_inc == target_q)) begin
                     state_d = StDone;
                  end
               end
            end
            StDone: begin
               if (start) begin
                  state_d = StRun;
                  cnt_d   = '0;
                  clear   = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         pattern_q <= '0;
         len_q     <= '0;
         overlap_q <= 1'b0;
         target_q  <= '0;
         loaded_q  <= 1'b0;
         cnt_q     <= '0;
         d_q       <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         len_q     <= len_d;
         overlap_q <= overlap_d;
         target_q  <= target_d;
         loaded_q  <= loaded_d;
         cnt_q     <= cnt_d;
         d_q       <= d_d;
         err_q     <= err_d;
      end
   end

   assign cfg_ready   = (state_q == StIdle);
   assign busy        = (state_q == StRun);
   assign done        = (state_q == StDone);
   assign d           = d_q;
   assign match_count = cnt_q;
   assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed, table-driven bench for seq_detect_ctrl.
module tb_seq_detect_ctrl;

   logic       clk;
   logic       reset;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic [7:0] cfg_target;
   logic       cfg_err;
   logic       start;
   logic       abort;
   logic       bit_valid;
   logic       bit_in;
   logic       d;
   logic [7:0] match_count;
   logic       busy;
   logic       done;

   seq_detect_ctrl #(
      .PAT_W (8),
      .CNT_W (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_target  (cfg_target),
      .cfg_err     (cfg_err),
      .start       (start),
      .abort       (abort),
      .bit_valid   (bit_valid),
      .bit_in      (bit_in),
      .d           (d),
      .match_count (match_count),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic       b;
      logic       ed;
      logic [7:0] ec;
      logic       edone;
   } vec_t;

   vec_t       vec[64];
   int         nvec;
   int         tests;
   int         fails;
   logic [0:14] stream;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic ov,
                            input logic [7:0] t, input logic exp_err, input string nm);
      cfg_valid   = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = ov;
      cfg_target  = t;
      step();
      cfg_valid = 1'b0;
      check({nm, ".cfg_err"}, 32'(cfg_err), 32'(exp_err));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   // Expected table from hand-listed hit positions; the target stop is modelled here.
   task automatic build(input logic [0:14] hits, input logic [0:14] gaps, input logic [7:0] tgt);
      logic [7:0] cnt;
      logic       dn;
      cnt  = '0;
      dn   = 1'b0;
      nvec = 0;
      for (int i = 0; i < 15; i++) begin
         if (!dn && hits[i]) begin
            cnt++;
            if (tgt != 0 && cnt == tgt) dn = 1'b1;
            vec[nvec] = '{1'b1, stream[i], 1'b1, cnt, dn};
         end else begin
            vec[nvec] = '{1'b1, stream[i], 1'b0, cnt, dn};
         end
         nvec++;
         if (gaps[i]) begin
            vec[nvec] = '{1'b0, 1'b0, 1'b0, cnt, dn};
            nvec++;
         end
      end
   endtask

   task automatic run_vecs(input string nm);
      for (int i = 0; i < nvec; i++) begin
         bit_valid = vec[i].v;
         bit_in    = vec[i].b;
         step();
         check($sformatf("%s[%0d].d", nm, i), 32'(d), 32'(vec[i].ed));
         check($sformatf("%s[%0d].cnt", nm, i), 32'(match_count), 32'(vec[i].ec));
         check($sformatf("%s[%0d].done", nm, i), 32'(done), 32'(vec[i].edone));
      end
      bit_valid = 1'b0;
   endtask

   initial begin
      tests       = 0;
      fails       = 0;
      stream      = 15'b110101011101010;
      reset       = 1'b0;
      cfg_valid   = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      cfg_target  = '0;
      start       = 1'b0;
      abort       = 1'b0;
      bit_valid   = 1'b0;
      bit_in      = 1'b0;

      #3;
      check("rst.cfg_ready", 32'(cfg_ready), 32'd1);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.d", 32'(d), 32'd0);
      check("rst.cnt", 32'(match_count), 32'd0);
      check("rst.cfg_err", 32'(cfg_err), 32'd0);
      #9 reset = 1'b1;

      // Start without any config is ignored.
      step();
      pulse_start();
      check("nocfg.busy", 32'(busy), 32'd0);

      // Illegal lengths pulse cfg_err for one cycle and load nothing.
      configure(8'h0A, 4'd0, 1'b1, 8'd0, 1'b1, "len0");
      step();
      check("len0.err_clears", 32'(cfg_err), 32'd0);
      configure(8'h0A, 4'd9, 1'b1, 8'd0, 1'b1, "len9");
      pulse_start();
      check("len9.busy", 32'(busy), 32'd0);

      // Overlapping 1010.
      configure(8'h0A, 4'd4, 1'b1, 8'd0, 1'b0, "ov");
      pulse_start();
      check("ov.busy", 32'(busy), 32'd1);
      build(15'b000010100000101, 15'b0, 8'd0);
      run_vecs("ov");
      pulse_abort();
      check("ov.abort_ready", 32'(cfg_ready), 32'd1);

      // Non-overlapping; a rejected config afterwards must not disturb it.
      configure(8'h0A, 4'd4, 1'b0, 8'd0, 1'b0, "nov");
      configure(8'hFF, 4'd0, 1'b1, 8'd0, 1'b1, "nov_bad");
      pulse_start();
      check("nov.cnt_cleared", 32'(match_count), 32'd0);
      build(15'b000010000000100, 15'b0, 8'd0);
      run_vecs("nov");
      pulse_abort();

      // Target of 3 stops in DONE; start re-arms with a cleared count.
      configure(8'h0A, 4'd4, 1'b1, 8'd3, 1'b0, "tgt");
      pulse_start();
      build(15'b000010100000101, 15'b0, 8'd3);
      run_vecs("tgt");
      pulse_start();
      check("tgt.rearm_busy", 32'(busy), 32'd1);
      check("tgt.rearm_done", 32'(done), 32'd0);
      check("tgt.rearm_cnt", 32'(match_count), 32'd0);
      pulse_abort();

      // Gaps mid-pattern give the gap-free result.
      configure(8'h0A, 4'd4, 1'b1, 8'd0, 1'b0, "gap");
      pulse_start();
      build(15'b000010100000101, 15'b001000000100010, 8'd0);
      run_vecs("gap");
      pulse_abort();

      // Abort on the cycle completing a match: no pulse, count held.
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         bit_valid = 1'b1;
         bit_in    = stream[i];
         step();
      end
      check("abm.cnt_before", 32'(match_count), 32'd1);
      bit_valid = 1'b1;
      bit_in    = stream[6];
      abort     = 1'b1;
      step();
      abort     = 1'b0;
      bit_valid = 1'b0;
      check("abm.d", 32'(d), 32'd0);
      check("abm.cnt", 32'(match_count), 32'd1);
      check("abm.ready", 32'(cfg_ready), 32'd1);

      // Abort beats start.
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      check("abst.busy", 32'(busy), 32'd0);

      // cfg_valid and start together: config wins, start ignored.
      cfg_valid   = 1'b1;
      cfg_pattern = 8'h01;
      cfg_len     = 4'd1;
      cfg_overlap = 1'b1;
      cfg_target  = 8'd0;
      start       = 1'b1;
      step();
      cfg_valid = 1'b0;
      start     = 1'b0;
      check("cfgst.busy", 32'(busy), 32'd0);

      // Counter saturation with a one-bit pattern of 1.
      pulse_start();
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      for (int i = 0; i < 260; i++) step();
      bit_valid = 1'b0;
      check("sat.cnt", 32'(match_count), 32'd255);
      check("sat.d", 32'(d), 32'd1);
      pulse_abort();

      // Asynchronous reset mid-RUN.
      configure(8'h0A, 4'd4, 1'b1, 8'd0, 1'b0, "ar");
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         bit_valid = 1'b1;
         bit_in    = stream[i];
         step();
      end
      bit_valid = 1'b0;
      check("ar.d_pre", 32'(d), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("ar.d", 32'(d), 32'd0);
      check("ar.busy", 32'(busy), 32'd0);
      check("ar.done", 32'(done), 32'd0);
      check("ar.cnt", 32'(match_count), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();
      check("ar.ready", 32'(cfg_ready), 32'd1);
      pulse_start();
      check("ar.cfg_lost", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
